// File: rtl/fifo_arb_pkg.sv
// Shared types and sizing helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t;

  function automatic int unsigned id_bits(input int unsigned n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational cyclic-priority picker: first set req bit at or after rr_ptr.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_BITS = id_bits(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_BITS-1:0] rr_ptr,
  output logic [ID_BITS-1:0] sel,
  output logic               any
);

  int unsigned        idx;
  logic [ID_BITS-1:0] cand;

  // Scan farthest-to-nearest so the candidate closest to rr_ptr wins last.
  always_comb begin
    sel  = '0;
    any  = 1'b0;
    idx  = 0;
    cand = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx  = (32'(rr_ptr) + NUM_REQ - 1 - k) % NUM_REQ;
      cand = ID_BITS'(idx);
      if (req[cand]) begin
        sel = cand;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin packet arbiter for the shared FIFO write port.
// Define ARB_CREDIT_GATE_EN to start packets only when the FIFO is fully empty of backlog.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned MAX_BURST = 4,
  parameter int unsigned MAX_CNT   = 3,
  parameter int unsigned CNT_BITS  = $clog2(MAX_CNT + 1),
  parameter int unsigned ID_BITS   = id_bits(NUM_REQ)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]       req_last,
  output logic [NUM_REQ-1:0]       gnt,
  output logic                     fifo_wr_en,
  output logic [WIDTH-1:0]         fifo_wr_data,
  input  logic                     fifo_wr_valid,
  input  logic                     fifo_full,
  input  logic [CNT_BITS-1:0]      fifo_spots,
  output logic [ID_BITS-1:0]       grant_id,
  output logic                     busy
);

  localparam int unsigned BC_BITS = $clog2(MAX_BURST + 1);

  arb_state_t         state;
  logic [ID_BITS-1:0] owner;
  logic [ID_BITS-1:0] rr_ptr;
  logic [BC_BITS-1:0] beat_cnt;

  logic [ID_BITS-1:0] pick_sel;
  logic               pick_any;
  logic               start_ok;
  logic [ID_BITS-1:0] sel;
  logic               wr_en;
  logic               acc;
  logic               end_pkt;
  logic [BC_BITS-1:0] beat_nxt;
  logic [ID_BITS-1:0] ptr_nxt;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_BITS (ID_BITS)
  ) u_pick (
    .req    (req),
    .rr_ptr (rr_ptr),
    .sel    (pick_sel),
    .any    (pick_any)
  );

`ifdef ARB_CREDIT_GATE_EN
  assign start_ok = (fifo_spots == CNT_BITS'(MAX_CNT)) & ~fifo_full;
`else
  logic unused_fifo_status;
  assign start_ok           = 1'b1;
  assign unused_fifo_status = ^{fifo_full, fifo_spots};
`endif

  // Select source and decide acceptance / packet end for this cycle.
  always_comb begin
    sel   = owner;
    wr_en = 1'b0;
    if (state == ARB_IDLE) begin
      sel   = pick_sel;
      wr_en = pick_any & start_ok;
    end else begin
      wr_en = req[owner];
    end
    acc      = wr_en & fifo_wr_valid;
    beat_nxt = beat_cnt + BC_BITS'(1);
    end_pkt  = req_last[sel] | (beat_nxt == BC_BITS'(MAX_BURST));
    ptr_nxt  = (32'(sel) == NUM_REQ - 1) ? '0 : sel + ID_BITS'(1);
  end

  // Outputs are held at zero while reset is asserted.
  always_comb begin
    gnt          = '0;
    fifo_wr_en   = 1'b0;
    fifo_wr_data = '0;
    grant_id     = '0;
    busy         = 1'b0;
    if (!reset) begin
      fifo_wr_en   = wr_en;
      fifo_wr_data = req_data[sel*WIDTH +: WIDTH];
      grant_id     = sel;
      busy         = (state == ARB_LOCKED);
      gnt[sel]     = acc;
    end
  end

  // Lock/release FSM; nothing moves unless a beat is actually accepted.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= ARB_IDLE;
      owner    <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else if (acc) begin
      if (end_pkt) begin
        state    <= ARB_IDLE;
        beat_cnt <= '0;
        rr_ptr   <= ptr_nxt;
      end else if (state == ARB_IDLE) begin
        state    <= ARB_LOCKED;
        owner    <= sel;
        beat_cnt <= BC_BITS'(1);
      end else begin
        beat_cnt <= beat_nxt;
      end
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed and randomized checks of fifo_wr_arbiter against a packet-level model.
module tb_fifo_wr_arbiter;

  localparam int unsigned NUM_REQ   = 4;
  localparam int unsigned WIDTH     = 16;
  localparam int unsigned MAX_BURST = 4;
  localparam int unsigned MAX_CNT   = 3;
  localparam int unsigned CNT_BITS  = 2;
  localparam int unsigned ID_BITS   = 2;

  logic                     clock = 1'b0;
  logic                     reset;
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]       req_last;
  logic [NUM_REQ-1:0]       gnt;
  logic                     fifo_wr_en;
  logic [WIDTH-1:0]         fifo_wr_data;
  logic                     fifo_wr_valid;
  logic                     fifo_full;
  logic [CNT_BITS-1:0]      fifo_spots;
  logic [ID_BITS-1:0]       grant_id;
  logic                     busy;

  always #5 clock = ~clock;

  fifo_wr_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .WIDTH     (WIDTH),
    .MAX_BURST (MAX_BURST),
    .MAX_CNT   (MAX_CNT)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .req           (req),
    .req_data      (req_data),
    .req_last      (req_last),
    .gnt           (gnt),
    .fifo_wr_en    (fifo_wr_en),
    .fifo_wr_data  (fifo_wr_data),
    .fifo_wr_valid (fifo_wr_valid),
    .fifo_full     (fifo_full),
    .fifo_spots    (fifo_spots),
    .grant_id      (grant_id),
    .busy          (busy)
  );

  // Packet-level model: who owns the port, how many beats taken, where the turn starts.
  bit m_locked;
  int m_owner, m_ptr, m_beats;

  int n_checks = 0;
  int n_fails  = 0;

  logic [NUM_REQ-1:0] last_gnt, exp_gnt;
  logic               last_busy, last_en;
  logic [WIDTH-1:0]   last_data;

  function automatic logic [WIDTH-1:0] beat_of(input int i);
    return req_data[i*WIDTH +: WIDTH];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare at negedge, then advance the model at posedge; inputs may change afterwards.
  task automatic cycle();
    int sel;
    bit any, en;
    sel = 0; any = 1'b0; en = 1'b0;
    @(negedge clock);
    if (reset) begin
      en = 1'b0;
    end else if (m_locked) begin
      sel = m_owner;
      en  = req[m_owner];
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!any && req[(m_ptr + k) % NUM_REQ]) begin
          any = 1'b1;
          sel = (m_ptr + k) % NUM_REQ;
        end
      end
      en = any;
`ifdef ARB_CREDIT_GATE_EN
      if (!(fifo_spots == CNT_BITS'(MAX_CNT) && !fifo_full)) en = 1'b0;
`endif
    end
    exp_gnt = '0;
    if (en && fifo_wr_valid) exp_gnt[sel] = 1'b1;
    chk("fifo_wr_en", 32'(fifo_wr_en), 32'(en));
    chk("gnt", 32'(gnt), 32'(exp_gnt));
    chk("busy", 32'(busy), 32'(!reset && m_locked));
    if (reset) begin
      chk("rst_data", 32'(fifo_wr_data), 32'(0));
      chk("rst_grant_id", 32'(grant_id), 32'(0));
    end else if (en) begin
      chk("fifo_wr_data", 32'(fifo_wr_data), 32'(beat_of(sel)));
      chk("grant_id", 32'(grant_id), 32'(sel));
    end
    last_gnt  = gnt;
    last_busy = busy;
    last_en   = fifo_wr_en;
    last_data = fifo_wr_data;
    @(posedge clock);
    if (reset) begin
      m_locked = 1'b0; m_owner = 0; m_ptr = 0; m_beats = 0;
    end else if (exp_gnt != '0) begin
      m_beats++;
      if (req_last[sel] || m_beats == int'(MAX_BURST)) begin
        m_locked = 1'b0;
        m_beats  = 0;
        m_ptr    = (sel + 1) % NUM_REQ;
      end else begin
        m_locked = 1'b1;
        m_owner  = sel;
      end
    end
    #1;
  endtask

  initial begin
    m_locked = 1'b0; m_owner = 0; m_ptr = 0; m_beats = 0;
    reset = 1'b1; req = '1; req_last = '1; fifo_wr_valid = 1'b1;
    fifo_full = 1'b0; fifo_spots = CNT_BITS'(MAX_CNT);
    for (int i = 0; i < NUM_REQ; i++) req_data[i*WIDTH +: WIDTH] = WIDTH'(16'hA000 + 16'(i * 16'h0111));

    // Reset holds every output low even with all requests up.
    cycle(); cycle();
    chk("rst_en_low", 32'(last_en), 32'(0));

    // 1: single-beat packets from producers 0 and 2 alternate.
    reset = 1'b0; req = 4'b0101; req_last = 4'b1111;
    cycle(); chk("t1_g0", 32'(last_gnt), 32'(4'b0001)); chk("t1_d0", 32'(last_data), 32'(beat_of(0)));
    cycle(); chk("t1_g1", 32'(last_gnt), 32'(4'b0100)); chk("t1_d1", 32'(last_data), 32'(beat_of(2)));
    cycle(); chk("t1_g2", 32'(last_gnt), 32'(4'b0001));
    cycle(); chk("t1_g3", 32'(last_gnt), 32'(4'b0100));
    req = '0; cycle();

    // 2: three-beat packet on producer 0 with producer 1 waiting.
    req = 4'b0011; req_last = 4'b0010;
    cycle(); chk("t2_b1", 32'(last_gnt), 32'(4'b0001)); chk("t2_b1_busy", 32'(last_busy), 32'(0));
    cycle(); chk("t2_b2", 32'(last_gnt), 32'(4'b0001)); chk("t2_b2_busy", 32'(last_busy), 32'(1));
    req_last = 4'b0011;
    cycle(); chk("t2_b3", 32'(last_gnt), 32'(4'b0001)); chk("t2_b3_busy", 32'(last_busy), 32'(1));
    req = 4'b0010;
    cycle(); chk("t2_g1", 32'(last_gnt), 32'(4'b0010));
    req = '0; cycle();

    // 3: endless packet on producer 0 is cut at the burst cap.
    req = 4'b0011; req_last = 4'b0010;
    for (int b = 0; b < 4; b++) begin
      cycle(); chk("t3_burst", 32'(last_gnt), 32'(4'b0001));
    end
    req = 4'b0010;
    cycle(); chk("t3_g1", 32'(last_gnt), 32'(4'b0010));
    req = '0; cycle();

    // 4: FIFO back-pressure mid-burst freezes everything.
    req = 4'b0001; req_last = 4'b0000;
    cycle(); chk("t4_b1", 32'(last_gnt), 32'(4'b0001));
    cycle(); chk("t4_b2", 32'(last_gnt), 32'(4'b0001));
    fifo_wr_valid = 1'b0;
    for (int s = 0; s < 3; s++) begin
      cycle();
      chk("t4_stall_en", 32'(last_en), 32'(1));
      chk("t4_stall_gnt", 32'(last_gnt), 32'(0));
      chk("t4_stall_data", 32'(last_data), 32'(beat_of(0)));
    end
    fifo_wr_valid = 1'b1;
    cycle(); chk("t4_b3", 32'(last_gnt), 32'(4'b0001));
    cycle(); chk("t4_b4", 32'(last_gnt), 32'(4'b0001)); chk("t4_b4_busy", 32'(last_busy), 32'(1));
    req = '0;
    cycle(); chk("t4_released", 32'(last_busy), 32'(0));

    // 5: reset in the middle of a producer-2 packet.
    req = 4'b0100; req_last = 4'b0000;
    cycle(); chk("t5_b1", 32'(last_gnt), 32'(4'b0100));
    req = 4'b1111; reset = 1'b1;
    cycle(); chk("t5_rst_gnt", 32'(last_gnt), 32'(0));
    reset = 1'b0;
    cycle(); chk("t5_after", 32'(last_gnt), 32'(4'b0001)); chk("t5_after_busy", 32'(last_busy), 32'(0));
    req = 4'b0001; req_last = 4'b0001;
    cycle(); chk("t5_close", 32'(last_gnt), 32'(4'b0001));
    req = '0; cycle();

`ifdef ARB_CREDIT_GATE_EN
    // 6: new packet needs a fully drained FIFO.
    req = 4'b0001; req_last = 4'b0001; fifo_spots = 2'd2;
    cycle(); chk("t6_gated", 32'(last_en), 32'(0));
    fifo_spots = 2'd3;
    cycle(); chk("t6_open", 32'(last_en), 32'(1)); chk("t6_gnt", 32'(last_gnt), 32'(4'b0001));
    req = '0; cycle();
`endif

    // Random traffic: producers hold a beat until granted, with rare drops and resets.
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (exp_gnt[i] || !req[i]) begin
          req[i]      = ($urandom_range(0, 2) != 0);
          req_last[i] = ($urandom_range(0, 2) == 0);
          req_data[i*WIDTH +: WIDTH] = WIDTH'($urandom);
        end else if ($urandom_range(0, 15) == 0) begin
          req[i] = 1'b0;
        end
      end
      fifo_wr_valid = ($urandom_range(0, 3) != 0);
      fifo_full     = ($urandom_range(0, 3) == 0);
      fifo_spots    = CNT_BITS'($urandom_range(0, MAX_CNT));
      reset         = ($urandom_range(0, 199) == 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
